// File: rtl/draw_command_queue.sv
// rtl/draw_command_queue.sv - frame-buffered command queue feeding the draw engine
//
// Purpose:
//   Commands from a producer are buffered in a FIFO. Once a complete frame
//   (terminated by an end-of-frame command) is queued, the back buffer is
//   optionally cleared. Each command is then issued to the draw engine in order,
//   and the block waits for draw_done after each one. At the end of the frame
//   swap_buffer is pulsed and the back-buffer base address toggles.
//
// Ports:
//   clock, reset                   system clock, asynchronous active-high reset
//   cmd_valid / cmd_ready          producer handshake
//   cmd_end_frame                  command closes its frame
//   cmd_opcode, cmd_ax..cmd_cy,    command fields (opcode 0 is a NOP)
//   cmd_colour
//   draw_en                        one-cycle start pulse to the draw engine
//   opcode, ax..cy, colour         registered command fields to the draw engine
//   draw_done                      draw engine finished the current command
//   clear_start / clear_done       back-buffer clear handshake
//   swap_buffer                    one-cycle pulse at end of frame
//   buffer_addr                    base address of the current back buffer
//   busy                           sequencer is not idle
//   frame_count                    completed frames (wraps)

module draw_command_queue #(
  parameter int          DEPTH     = 16,
  parameter int          ADDR_W    = 4,
  parameter logic [31:0] BUF0_ADDR = 32'h0000_0000,
  parameter logic [31:0] BUF1_ADDR = 32'h0012_C000,
  parameter bit          CLEAR_EN  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_end_frame,
  input  logic [3:0]  cmd_opcode,
  input  logic [15:0] cmd_ax,
  input  logic [15:0] cmd_ay,
  input  logic [15:0] cmd_bx,
  input  logic [15:0] cmd_by,
  input  logic [15:0] cmd_cx,
  input  logic [15:0] cmd_cy,
  input  logic [31:0] cmd_colour,

  output logic        draw_en,
  output logic [3:0]  opcode,
  output logic [15:0] ax,
  output logic [15:0] ay,
  output logic [15:0] bx,
  output logic [15:0] by,
  output logic [15:0] cx,
  output logic [15:0] cy,
  output logic [31:0] colour,
  input  logic        draw_done,

  output logic        clear_start,
  input  logic        clear_done,

  output logic        swap_buffer,
  output logic [31:0] buffer_addr,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int ENTRY_W = 133;
  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR_START,
    S_CLEAR_WAIT,
    S_POP,
    S_DRAW_START,
    S_DRAW_WAIT,
    S_SWAP
  } state_t;

  state_t state;

  // FIFO storage and bookkeeping
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W:0]    count;
  logic [ADDR_W:0]    pending;

  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;
  logic               push;
  logic               pop;
  logic               eof_flag;

  // Head-of-queue fields
  logic               head_eof;
  logic [3:0]         head_opcode;
  logic [15:0]        head_ax;
  logic [15:0]        head_ay;
  logic [15:0]        head_bx;
  logic [15:0]        head_by;
  logic [15:0]        head_cx;
  logic [15:0]        head_cy;
  logic [31:0]        head_colour;

  assign wr_entry = {cmd_end_frame, cmd_opcode, cmd_ax, cmd_ay, cmd_bx, cmd_by,
                     cmd_cx, cmd_cy, cmd_colour};
  assign head     = mem[rd_ptr];

  assign head_eof    = head[132];
  assign head_opcode = head[131:128];
  assign head_ax     = head[127:112];
  assign head_ay     = head[111:96];
  assign head_bx     = head[95:80];
  assign head_by     = head[79:64];
  assign head_cx     = head[63:48];
  assign head_cy     = head[47:32];
  assign head_colour = head[31:0];

  // The final slot only takes an end-of-frame command. A full queue therefore
  // always holds a complete frame, and the sequencer can always drain it.
  assign cmd_ready = (count < LAST_SLOT) || ((count == LAST_SLOT) && cmd_end_frame);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == S_POP) && (count != '0);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pending <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case ({push && cmd_end_frame, pop && head_eof})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end

  // Sequencer. Pulse outputs default low every cycle and are raised only on the
  // transition into the state they announce, so each is high for exactly one
  // cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      draw_en     <= 1'b0;
      clear_start <= 1'b0;
      swap_buffer <= 1'b0;
      eof_flag    <= 1'b0;
      opcode      <= '0;
      ax          <= '0;
      ay          <= '0;
      bx          <= '0;
      by          <= '0;
      cx          <= '0;
      cy          <= '0;
      colour      <= '0;
      buffer_addr <= BUF1_ADDR;
      frame_count <= '0;
    end else begin
      draw_en     <= 1'b0;
      clear_start <= 1'b0;
      swap_buffer <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pending != '0) begin
            if (CLEAR_EN) begin
              state       <= S_CLEAR_START;
              clear_start <= 1'b1;
            end else begin
              state <= S_POP;
            end
          end
        end

        S_CLEAR_START: begin
          state <= S_CLEAR_WAIT;
        end

        S_CLEAR_WAIT: begin
          if (clear_done) begin
            state <= S_POP;
          end
        end

        S_POP: begin
          // Fields are latched even for NOPs; they stay stable until the next pop.
          opcode   <= head_opcode;
          ax       <= head_ax;
          ay       <= head_ay;
          bx       <= head_bx;
          by       <= head_by;
          cx       <= head_cx;
          cy       <= head_cy;
          colour   <= head_colour;
          eof_flag <= head_eof;
          if (head_opcode != 4'd0) begin
            state   <= S_DRAW_START;
            draw_en <= 1'b1;
          end else if (head_eof) begin
            state       <= S_SWAP;
            swap_buffer <= 1'b1;
          end else begin
            state <= S_POP;
          end
        end

        S_DRAW_START: begin
          state <= S_DRAW_WAIT;
        end

        S_DRAW_WAIT: begin
          if (draw_done) begin
            if (eof_flag) begin
              state       <= S_SWAP;
              swap_buffer <= 1'b1;
            end else begin
              state <= S_POP;
            end
          end
        end

        S_SWAP: begin
          buffer_addr <= (buffer_addr == BUF0_ADDR) ? BUF1_ADDR : BUF0_ADDR;
          frame_count <= frame_count + 16'd1;
          state       <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_command_queue.sv
// tb/tb_draw_command_queue.sv - directed self-checking bench for draw_command_queue

module tb_draw_command_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, nc_valid;
  logic        cmd_end_frame;
  logic [3:0]  cmd_opcode;
  logic [15:0] cmd_ax, cmd_ay, cmd_bx, cmd_by, cmd_cx, cmd_cy;
  logic [31:0] cmd_colour;
  logic        draw_done, clear_done;

  logic        cmd_ready, draw_en, clear_start, swap_buffer, busy;
  logic [3:0]  opcode;
  logic [15:0] ax, ay, bx, by, cx, cy, frame_count;
  logic [31:0] colour, buffer_addr;

  logic        nc_ready, nc_draw_en, nc_clear_start, nc_swap_buffer, nc_busy;
  logic [3:0]  nc_opcode;
  logic [15:0] nc_ax, nc_ay, nc_bx, nc_by, nc_cx, nc_cy, nc_frame_count;
  logic [31:0] nc_colour, nc_buffer_addr;

  int vectors = 0;
  int errors  = 0;
  int draw_cnt, clear_cnt, swap_cnt, clear_served;
  int op_log[$];
  int ax_log[$];

  always #5 clock = ~clock;

  draw_command_queue #(.CLEAR_EN(1'b1)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_end_frame(cmd_end_frame),
    .cmd_opcode(cmd_opcode), .cmd_ax(cmd_ax), .cmd_ay(cmd_ay), .cmd_bx(cmd_bx),
    .cmd_by(cmd_by), .cmd_cx(cmd_cx), .cmd_cy(cmd_cy), .cmd_colour(cmd_colour),
    .draw_en(draw_en), .opcode(opcode), .ax(ax), .ay(ay), .bx(bx), .by(by),
    .cx(cx), .cy(cy), .colour(colour), .draw_done(draw_done),
    .clear_start(clear_start), .clear_done(clear_done), .swap_buffer(swap_buffer),
    .buffer_addr(buffer_addr), .busy(busy), .frame_count(frame_count)
  );

  draw_command_queue #(.CLEAR_EN(1'b0)) dut_nc (
    .clock(clock), .reset(reset),
    .cmd_valid(nc_valid), .cmd_ready(nc_ready), .cmd_end_frame(cmd_end_frame),
    .cmd_opcode(cmd_opcode), .cmd_ax(cmd_ax), .cmd_ay(cmd_ay), .cmd_bx(cmd_bx),
    .cmd_by(cmd_by), .cmd_cx(cmd_cx), .cmd_cy(cmd_cy), .cmd_colour(cmd_colour),
    .draw_en(nc_draw_en), .opcode(nc_opcode), .ax(nc_ax), .ay(nc_ay), .bx(nc_bx),
    .by(nc_by), .cx(nc_cx), .cy(nc_cy), .colour(nc_colour), .draw_done(draw_done),
    .clear_start(nc_clear_start), .clear_done(clear_done),
    .swap_buffer(nc_swap_buffer), .buffer_addr(nc_buffer_addr), .busy(nc_busy),
    .frame_count(nc_frame_count)
  );

  // Pulse monitor for the CLEAR_EN=1 instance
  always @(negedge clock) begin
    if (draw_en) begin
      draw_cnt++;
      op_log.push_back(int'(opcode));
      ax_log.push_back(int'(ax));
    end
    if (clear_start) clear_cnt++;
    if (swap_buffer) swap_cnt++;
  end

  task automatic clear_counters();
    draw_cnt = 0; clear_cnt = 0; swap_cnt = 0; clear_served = 0;
    op_log.delete();
    ax_log.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic hw_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    idle(1);
  endtask

  task automatic push(input logic [3:0] op, input logic [15:0] x0, input logic [15:0] y0,
                      input logic [15:0] x1, input logic [15:0] y1, input logic [15:0] x2,
                      input logic [15:0] y2, input logic [31:0] col, input logic eof);
    cmd_opcode = op; cmd_ax = x0; cmd_ay = y0; cmd_bx = x1; cmd_by = y1;
    cmd_cx = x2; cmd_cy = y2; cmd_colour = col; cmd_end_frame = eof;
    cmd_valid = 1'b1;
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    cmd_end_frame = 1'b0;
  endtask

  task automatic push_simple(input logic [3:0] op, input logic [15:0] x, input logic eof);
    push(op, x, x + 16'd1, x + 16'd2, x + 16'd3, x + 16'd4, x + 16'd5,
         32'hC000_0000 | {16'h0, x}, eof);
  endtask

  // Acts as draw engine and clear engine until exp_swaps frames have completed.
  task automatic service(input int exp_swaps, input int delay, input int budget);
    int dt = 0;
    int ct = 0;
    int c  = 0;
    while (swap_cnt < exp_swaps && c < budget) begin
      @(negedge clock);
      c++;
      draw_done  = 1'b0;
      clear_done = 1'b0;
      if (dt > 0) begin dt--; if (dt == 0) draw_done = 1'b1; end
      if (ct > 0) begin ct--; if (ct == 0) clear_done = 1'b1; end
      if (draw_en) dt = delay;
      if (ct == 0 && clear_cnt > clear_served) begin clear_served++; ct = 2; end
    end
    @(posedge clock);
    #1 draw_done = 1'b0;
    clear_done = 1'b0;
    vectors++;
    if (swap_cnt < exp_swaps) begin
      errors++;
      $display("FAIL service_timeout swaps=%0d required=%0d", swap_cnt, exp_swaps);
    end
  endtask

  task automatic test_reset();
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    vectors++; if (draw_en !== 1'b0 || clear_start !== 1'b0 || swap_buffer !== 1'b0) begin
      errors++; $display("FAIL rst_pulses got=%b%b%b exp=000", draw_en, clear_start, swap_buffer); end
    vectors++; if (buffer_addr !== 32'h0012_C000) begin errors++; $display("FAIL rst_buffer_addr got=%h exp=0012c000", buffer_addr); end
    vectors++; if (frame_count !== 16'd0) begin errors++; $display("FAIL rst_frame_count got=%0d exp=0", frame_count); end
    vectors++; if (opcode !== 4'd0 || ax !== 16'd0 || colour !== 32'd0) begin
      errors++; $display("FAIL rst_fields got=%h/%h/%h exp=0/0/0", opcode, ax, colour); end
    vectors++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_latency();
    cmd_opcode = 4'd9; cmd_ax = 16'h1234; cmd_end_frame = 1'b1; nc_valid = 1'b1;
    @(posedge clock);
    #1 nc_valid = 1'b0;
    cmd_end_frame = 1'b0;
    vectors++; if (nc_busy !== 1'b0) begin errors++; $display("FAIL lat_T_busy got=%b exp=0", nc_busy); end
    idle(1);
    vectors++; if (nc_busy !== 1'b1 || nc_draw_en !== 1'b0) begin
      errors++; $display("FAIL lat_T1 got busy=%b draw_en=%b exp busy=1 draw_en=0", nc_busy, nc_draw_en); end
    idle(1);
    vectors++; if (nc_draw_en !== 1'b1 || nc_opcode !== 4'd9 || nc_ax !== 16'h1234) begin
      errors++; $display("FAIL lat_T2 got draw_en=%b op=%h ax=%h exp 1/9/1234", nc_draw_en, nc_opcode, nc_ax); end
    vectors++; if (nc_clear_start !== 1'b0) begin errors++; $display("FAIL lat_no_clear got=%b exp=0", nc_clear_start); end
    idle(1);
    draw_done = 1'b1;
    idle(1);
    draw_done = 1'b0;
    idle(3);
    vectors++; if (nc_frame_count !== 16'd1 || nc_buffer_addr !== 32'h0 || nc_busy !== 1'b0) begin
      errors++; $display("FAIL lat_swap got fc=%0d addr=%h busy=%b exp 1/00000000/0", nc_frame_count, nc_buffer_addr, nc_busy); end
  endtask

  task automatic test_single_frame();
    clear_counters();
    push(4'd1, 16'd0, 16'd0, 16'd300, 16'd100, 16'd100, 16'd300, 32'hFF00_FF00, 1'b1);
    service(1, 3, 200);
    vectors++; if (clear_cnt !== 1) begin errors++; $display("FAIL single_clear_pulses got=%0d exp=1", clear_cnt); end
    vectors++; if (draw_cnt !== 1) begin errors++; $display("FAIL single_draw_pulses got=%0d exp=1", draw_cnt); end
    vectors++; if (swap_cnt !== 1) begin errors++; $display("FAIL single_swaps got=%0d exp=1", swap_cnt); end
    vectors++; if (opcode !== 4'd1 || ax !== 16'd0 || ay !== 16'd0 || bx !== 16'd300 ||
                   by !== 16'd100 || cx !== 16'd100 || cy !== 16'd300 || colour !== 32'hFF00_FF00) begin
      errors++; $display("FAIL single_fields got op=%0d %0d,%0d %0d,%0d %0d,%0d col=%h exp 1 0,0 300,100 100,300 ff00ff00",
                         opcode, ax, ay, bx, by, cx, cy, colour); end
    vectors++; if (buffer_addr !== 32'h0) begin errors++; $display("FAIL single_buffer_addr got=%h exp=00000000", buffer_addr); end
    vectors++; if (frame_count !== 16'd1) begin errors++; $display("FAIL single_frame_count got=%0d exp=1", frame_count); end
  endtask

  task automatic test_partial_frame();
    int exp_ops[4] = '{2, 3, 4, 5};
    int bad = 0;
    clear_counters();
    push_simple(4'd2, 16'd10, 1'b0);
    push_simple(4'd3, 16'd20, 1'b0);
    push_simple(4'd4, 16'd30, 1'b0);
    idle(5);
    vectors++; if (draw_cnt !== 0 || clear_cnt !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL partial_no_start got draws=%0d clears=%0d busy=%b exp 0/0/0", draw_cnt, clear_cnt, busy); end
    push_simple(4'd5, 16'd40, 1'b1);
    service(1, 2, 300);
    vectors++; if (draw_cnt !== 4) begin errors++; $display("FAIL partial_draws got=%0d exp=4", draw_cnt); end
    if (op_log.size() == 4) begin
      for (int i = 0; i < 4; i++) if (op_log[i] != exp_ops[i] || ax_log[i] != 10 * (i + 1)) bad++;
      vectors++; if (bad != 0) begin errors++; $display("FAIL partial_order got %0d wrong entries exp=0", bad); end
    end
    vectors++; if (swap_cnt !== 1 || frame_count !== 16'd2 || buffer_addr !== 32'h0012_C000) begin
      errors++; $display("FAIL partial_swap got swaps=%0d fc=%0d addr=%h exp 1/2/0012c000", swap_cnt, frame_count, buffer_addr); end
  endtask

  task automatic test_full_fifo();
    int bad = 0;
    clear_counters();
    for (int i = 0; i < 15; i++) push_simple(4'((i % 15) + 1), 16'(i), 1'b0);
    cmd_valid = 1'b0; cmd_end_frame = 1'b0;
    #1;
    vectors++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready_non_eof got=%b exp=0", cmd_ready); end
    cmd_end_frame = 1'b1;
    #1;
    vectors++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_ready_eof got=%b exp=1", cmd_ready); end
    cmd_end_frame = 1'b0;
    push_simple(4'd1, 16'd15, 1'b1);
    service(1, 1, 600);
    vectors++; if (draw_cnt !== 16) begin errors++; $display("FAIL full_draws got=%0d exp=16", draw_cnt); end
    if (ax_log.size() == 16) begin
      for (int i = 0; i < 16; i++) if (ax_log[i] != i) bad++;
      vectors++; if (bad != 0) begin errors++; $display("FAIL full_order got %0d wrong entries exp=0", bad); end
    end
    #1;
    vectors++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after got=%b exp=1", cmd_ready); end
    vectors++; if (frame_count !== 16'd3 || buffer_addr !== 32'h0) begin
      errors++; $display("FAIL full_swap got fc=%0d addr=%h exp 3/00000000", frame_count, buffer_addr); end
  endtask

  task automatic test_nop_frame();
    clear_counters();
    push_simple(4'd0, 16'd1, 1'b0);
    push_simple(4'd6, 16'd2, 1'b0);
    push_simple(4'd0, 16'd3, 1'b0);
    push_simple(4'd7, 16'd4, 1'b0);
    push_simple(4'd0, 16'd5, 1'b1);
    service(1, 2, 300);
    vectors++; if (draw_cnt !== 2) begin errors++; $display("FAIL nop_draws got=%0d exp=2", draw_cnt); end
    if (op_log.size() == 2) begin
      vectors++; if (op_log[0] != 6 || op_log[1] != 7 || ax_log[0] != 2 || ax_log[1] != 4) begin
        errors++; $display("FAIL nop_order got ops=%0d,%0d exp=6,7", op_log[0], op_log[1]); end
    end
    vectors++; if (swap_cnt !== 1 || frame_count !== 16'd4) begin
      errors++; $display("FAIL nop_swap got swaps=%0d fc=%0d exp 1/4", swap_cnt, frame_count); end
    vectors++; if (opcode !== 4'd0 || ax !== 16'd5) begin
      errors++; $display("FAIL nop_latched got op=%0d ax=%0d exp 0/5", opcode, ax); end
  endtask

  task automatic test_back_to_back();
    hw_reset();
    clear_counters();
    push_simple(4'd1, 16'd100, 1'b0);
    push_simple(4'd2, 16'd101, 1'b1);
    push_simple(4'd3, 16'd102, 1'b1);
    service(2, 50, 800);
    vectors++; if (draw_cnt !== 3 || clear_cnt !== 2) begin
      errors++; $display("FAIL b2b_pulses got draws=%0d clears=%0d exp 3/2", draw_cnt, clear_cnt); end
    if (op_log.size() == 3) begin
      vectors++; if (op_log[0] != 1 || op_log[1] != 2 || op_log[2] != 3) begin
        errors++; $display("FAIL b2b_order got %0d,%0d,%0d exp 1,2,3", op_log[0], op_log[1], op_log[2]); end
    end
    idle(2);
    vectors++; if (swap_cnt !== 2 || frame_count !== 16'd2 || buffer_addr !== 32'h0012_C000 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_end got swaps=%0d fc=%0d addr=%h busy=%b exp 2/2/0012c000/0",
                         swap_cnt, frame_count, buffer_addr, busy); end
  endtask

  task automatic test_reset_mid_frame();
    int c = 0;
    clear_counters();
    push_simple(4'd1, 16'd7, 1'b1);
    for (int i = 0; i < 4; i++) push_simple(4'(i + 2), 16'(i + 8), 1'b0);
    push_simple(4'd6, 16'd12, 1'b1);
    clear_done = 1'b1;
    idle(1);
    clear_done = 1'b0;
    while (draw_cnt < 1 && c < 20) begin idle(1); c++; end
    idle(3);
    vectors++; if (busy !== 1'b1 || opcode !== 4'd1 || clear_cnt !== 1) begin
      errors++; $display("FAIL midrst_pre got busy=%b op=%0d clears=%0d exp 1/1/1", busy, opcode, clear_cnt); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0 || draw_en !== 1'b0 || clear_start !== 1'b0 || swap_buffer !== 1'b0 ||
                   opcode !== 4'd0 || ax !== 16'd0 || colour !== 32'd0) begin
      errors++; $display("FAIL midrst_outputs got busy=%b op=%h ax=%h col=%h exp all 0", busy, opcode, ax, colour); end
    vectors++; if (buffer_addr !== 32'h0012_C000 || frame_count !== 16'd0) begin
      errors++; $display("FAIL midrst_addr got addr=%h fc=%0d exp 0012c000/0", buffer_addr, frame_count); end
    @(posedge clock);
    #1 reset = 1'b0;
    draw_done = 1'b1;
    idle(1);
    draw_done = 1'b0;
    idle(10);
    vectors++; if (draw_cnt !== 1 || swap_cnt !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_ignored got draws=%0d swaps=%0d busy=%b exp 1/0/0", draw_cnt, swap_cnt, busy); end
    clear_counters();
    push_simple(4'hA, 16'h55, 1'b1);
    service(1, 2, 200);
    vectors++; if (draw_cnt !== 1 || frame_count !== 16'd1) begin
      errors++; $display("FAIL midrst_empty got draws=%0d fc=%0d exp 1/1", draw_cnt, frame_count); end
    if (op_log.size() == 1) begin
      vectors++; if (op_log[0] != 10 || ax_log[0] != 16'h55) begin
        errors++; $display("FAIL midrst_entry got op=%0d ax=%h exp 10/55", op_log[0], ax_log[0]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; nc_valid = 1'b0; cmd_end_frame = 1'b0; cmd_opcode = '0;
    cmd_ax = '0; cmd_ay = '0; cmd_bx = '0; cmd_by = '0; cmd_cx = '0; cmd_cy = '0;
    cmd_colour = '0; draw_done = 1'b0; clear_done = 1'b0;
    clear_counters();
    hw_reset();
    test_reset();
    test_latency();
    test_single_frame();
    test_partial_frame();
    test_full_fifo();
    test_nop_frame();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
